// File: rtl/mem_access.sv
// MEM stage with MEM/WB register: runs a req/ack data-bus cycle for loads/stores and stalls until answered.
// Optional bus timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [2:0]  mem_op,
   input  logic [31:0] mem_sdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall_req,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        exc_misalign,
   output logic        exc_bus
);

   // state   | meaning
   // ST_IDLE | evaluate the op on the EX/MEM inputs, launch a bus cycle if needed
   // ST_WAIT | bus request outstanding, pipeline frozen until ack (or timeout)
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  wb_wd_q, wb_wd_d;
   logic        wb_wreg_q, wb_wreg_d;
   logic [31:0] wb_wdata_q, wb_wdata_d;
   logic        exc_misalign_q, exc_misalign_d;

   logic        is_lw, is_lb, is_lbu, is_sw, is_sb, is_mem, is_load_q, misalign, expire;
   logic [7:0]  lane_byte;
   logic [31:0] load_data;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   assign is_lw    = (mem_op == 3'b001);
   assign is_lb    = (mem_op == 3'b010);
   assign is_lbu   = (mem_op == 3'b011);
   assign is_sw    = (mem_op == 3'b100);
   assign is_sb    = (mem_op == 3'b101);
   assign is_mem   = is_lw | is_lb | is_lbu | is_sw | is_sb;
   assign misalign = (is_lw | is_sw) && (mem_wdata[1:0] != 2'b00);
   assign is_load_q = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b011);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exc_bus_q, exc_bus_d;

   // an ack arriving in the expiry cycle still completes normally
   assign expire    = (state_q == ST_WAIT) && !bus_ack && (cnt_q == CNT_LAST);
   assign cnt_d     = ((state_q == ST_WAIT) && !bus_ack && !expire) ? cnt_q + CNT_W'(1) : '0;
   assign exc_bus_d = expire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         exc_bus_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         exc_bus_q <= exc_bus_d;
      end
   end

   assign exc_bus = exc_bus_q;
`else
   assign expire  = 1'b0;
   assign exc_bus = 1'b0;
`endif

   // big-endian lanes: byte offset 0 lives in bits 31:24
   always_comb begin
      case (off_q)
         2'd0:    lane_byte = bus_rdata[31:24];
         2'd1:    lane_byte = bus_rdata[23:16];
         2'd2:    lane_byte = bus_rdata[15:8];
         default: lane_byte = bus_rdata[7:0];
      endcase
      if (op_q == 3'b010)      load_data = {{24{lane_byte[7]}}, lane_byte};
      else if (op_q == 3'b011) load_data = {24'h0, lane_byte};
      else                     load_data = bus_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_sel_q      <= '0;
         bus_wdata_q    <= '0;
         op_q           <= '0;
         off_q          <= '0;
         wb_wd_q        <= '0;
         wb_wreg_q      <= 1'b0;
         wb_wdata_q     <= '0;
         exc_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bus_req_q      <= bus_req_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_sel_q      <= bus_sel_d;
         bus_wdata_q    <= bus_wdata_d;
         op_q           <= op_d;
         off_q          <= off_d;
         wb_wd_q        <= wb_wd_d;
         wb_wreg_q      <= wb_wreg_d;
         wb_wdata_q     <= wb_wdata_d;
         exc_misalign_q <= exc_misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (is_mem && !misalign) state_d = ST_WAIT;
         default: if (bus_ack || expire)   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stall_req      = 1'b0;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_sel_d      = bus_sel_q;
      bus_wdata_d    = bus_wdata_q;
      op_d           = op_q;
      off_d          = off_q;
      wb_wd_d        = wb_wd_q;
      wb_wreg_d      = wb_wreg_q;
      wb_wdata_d     = wb_wdata_q;
      exc_misalign_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!is_mem) begin
               wb_wd_d    = mem_wd;
               wb_wreg_d  = mem_wreg;
               wb_wdata_d = mem_wdata;
            end else if (misalign) begin
               wb_wreg_d      = 1'b0;
               exc_misalign_d = 1'b1;
            end else begin
               stall_req   = 1'b1;
               bus_req_d   = 1'b1;
               bus_we_d    = is_sw | is_sb;
               bus_addr_d  = {mem_wdata[31:2], 2'b00};
               bus_sel_d   = (is_lw | is_sw) ? 4'b1111 : (4'b1000 >> mem_wdata[1:0]);
               bus_wdata_d = is_sb ? {4{mem_sdata[7:0]}} : mem_sdata;
               op_d        = mem_op;
               off_d       = mem_wdata[1:0];
               wb_wreg_d   = 1'b0;
            end
         end
         default: begin
            stall_req = !bus_ack && !expire;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (is_load_q) begin
                  wb_wd_d    = mem_wd;
                  wb_wreg_d  = mem_wreg;
                  wb_wdata_d = load_data;
               end else begin
                  wb_wreg_d = 1'b0;
               end
            end else if (expire) begin
               bus_req_d = 1'b0;
               wb_wreg_d = 1'b0;
            end
         end
      endcase
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_sel      = bus_sel_q;
   assign bus_wdata    = bus_wdata_q;
   assign wb_wd        = wb_wd_q;
   assign wb_wreg      = wb_wreg_q;
   assign wb_wdata     = wb_wdata_q;
   assign exc_misalign = exc_misalign_q;

endmodule
